conf_mul_sequencer: RTL
=======================

CONF_MUL_SEQUENCER -- requirements
Module: conf_mul_sequencer

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning wrapper latency in cycles from operand acceptance to valid P.
REQ-002 SHALL have parameter WARMUP, default 64, meaning WARMUP-state length in cycles; count0 runs 0..WARMUP-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-004 SHALL have port rstP, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: begin a job; sampled only in IDLE.
REQ-006 SHALL have port mode, input, 1 bit: 0 = accurate, 1 = approximate; latched on start.
REQ-007 SHALL have port num_ops, input, 9 bits: number of operand pairs in the job; latched on start.
REQ-008 SHALL have port abort, input, 1 bit: cancel the current job.
REQ-009 SHALL have port in_valid, input, 1 bit: operand pair present on the wrapper A/B inputs.
REQ-010 SHALL have port in_ready, output, 1 bit: operand pair accepted this cycle when in_valid=1.
REQ-011 SHALL have port state, output, 3 bits: wrapper state code.
REQ-012 SHALL have port count0, output, 9 bits: wrapper cycle/op counter.
REQ-013 SHALL have port mul_rstP, output, 1 bit: drives the wrapper rstP.
REQ-014 SHALL have port racc, output, 1 bit: wrapper accurate-bit reset.
REQ-015 SHALL have port rapx, output, 1 bit: wrapper approximate-bit reset.
REQ-016 SHALL have port out_valid, output, 1 bit: wrapper P valid this cycle.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-018 SHALL have port done, output, 1 bit: single-cycle pulse on job completion.

Function
REQ-019 SHALL implement states IDLE=000, WARMUP=001, RUN_ACC=010, RUN_APX=011, DRAIN=100.
REQ-020 SHALL, in IDLE with start=1 and abort=0, latch mode and num_ops and go to WARMUP with count0=0; if num_ops=0, SHALL instead stay in IDLE and pulse done next cycle.
REQ-021 SHALL, in WARMUP, increment count0 each cycle; at count0=WARMUP-1 it SHALL go to RUN_ACC (mode=0) or RUN_APX (mode=1) and clear count0.
REQ-022 SHALL, in RUN_*, drive in_ready=1 while count0<num_ops, and count0 SHALL increment on each in_valid&in_ready.
REQ-023 SHALL leave RUN_* for DRAIN in the cycle after the num_ops-th acceptance.
REQ-024 SHALL produce out_valid exactly LAT cycles after each acceptance via an LAT-deep shift register that is independent of state.
REQ-025 SHALL, in DRAIN, go to IDLE and pulse done once the shift register is empty.
REQ-026 SHALL drive racc=1 in IDLE and 0 otherwise; mul_rstP=1 in IDLE/WARMUP and 0 otherwise; rapx=latched mode outside IDLE and 0 in IDLE.
REQ-027 SHALL drive in_ready=0 in every state except RUN_*.
REQ-028 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle, clear count0 and the shift register, and suppress out_valid and done.
REQ-029 SHALL give abort priority over start when both are high in IDLE (stay IDLE).
REQ-030 SHALL ignore start while busy=1.

Reset
REQ-031 SHALL, on rstP=1 at a clock edge, force state=IDLE, count0=0, shift register cleared, in_ready=0, out_valid=0, done=0, busy=0, racc=1, mul_rstP=1, rapx=0, and latched mode/num_ops=0, including when asserted mid-job.

Configuration
REQ-032 SHALL, with CONF_MUL_SEQ_PERF_CNT_EN defined, add output apx_ops (16 bits, reset 0) that counts acceptances in RUN_APX, saturates at 0xFFFF, and is not cleared by abort.
REQ-033 SHALL, without CONF_MUL_SEQ_PERF_CNT_EN, omit the apx_ops port and its counter entirely.

Verification
REQ-034 Bench SHALL cover: start, mode=0, num_ops=3, in_valid held high -> 64 WARMUP cycles; 3 accepts in RUN_ACC (010); out_valid at accept+2; done pulses once; state returns to 000.
REQ-035 Bench SHALL cover: start, mode=1, num_ops=2 -> state=011 and rapx=1 during RUN/DRAIN; apx_ops=2 when the macro is defined.
REQ-036 Bench SHALL cover: num_ops=0 -> done pulse with no WARMUP, busy stays 0.
REQ-037 Bench SHALL cover: abort at the 2nd accept of 5 -> IDLE next cycle, no further out_valid, no done.
REQ-038 Bench SHALL cover: rstP asserted during DRAIN -> all outputs at reset values next cycle.
REQ-039 Bench SHALL cover: in_valid gapped (1 of every 3 cycles), num_ops=4 -> count0 advances only on accepts, exactly 4 out_valid pulses.

Source files
------------

// File: rtl/conf_mul_sequencer.sv
// Operand/reset sequencer for a configurable accurate/approximate multiplier wrapper.
// Define CONF_MUL_SEQ_PERF_CNT_EN to add the apx_ops acceptance counter output.
module conf_mul_sequencer #(
  parameter int LAT    = 2,
  parameter int WARMUP = 64
) (
  input  logic       clk,
  input  logic       rstP,
  input  logic       start,
  input  logic       mode,
  input  logic [8:0] num_ops,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] state,
  output logic [8:0] count0,
  output logic       mul_rstP,
  output logic       racc,
  output logic       rapx,
  output logic       out_valid,
  output logic       busy,
`ifdef CONF_MUL_SEQ_PERF_CNT_EN
  output logic [15:0] apx_ops,
`endif
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_WARMUP  = 3'b001,
    S_RUN_ACC = 3'b010,
    S_RUN_APX = 3'b011,
    S_DRAIN   = 3'b100
  } state_t;

  localparam logic [8:0] WARM_LAST = 9'(WARMUP - 1);

  state_t           r_state;
  logic [8:0]       r_count0;
  logic [8:0]       r_num_ops;
  logic             r_mode;
  logic             r_done;
  logic [LAT-1:0]   r_sr;

  logic w_busy;
  logic w_run;
  logic w_accept;
  logic w_sr_clr;

  assign w_busy   = (r_state != S_IDLE);
  assign w_run    = (r_state == S_RUN_ACC) || (r_state == S_RUN_APX);
  assign in_ready = w_run && (r_count0 < r_num_ops);
  assign w_accept = in_valid && in_ready;
  assign w_sr_clr = rstP || (abort && w_busy);

  // Latency pipe tracks accepted operands only; it keeps shifting regardless of FSM state.
  always_ff @(posedge clk) begin
    if (w_sr_clr) r_sr[0] <= 1'b0;
    else          r_sr[0] <= w_accept;
  end

  for (genvar gi = 1; gi < LAT; gi++) begin : g_sr
    always_ff @(posedge clk) begin
      if (w_sr_clr) r_sr[gi] <= 1'b0;
      else          r_sr[gi] <= r_sr[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rstP) begin
      r_state   <= S_IDLE;
      r_count0  <= '0;
      r_num_ops <= '0;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort && w_busy) begin
        r_state  <= S_IDLE;
        r_count0 <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_mode    <= mode;
              r_num_ops <= num_ops;
              r_count0  <= '0;
              // An empty job completes immediately without touching the multiplier.
              if (num_ops == 9'd0) r_done  <= 1'b1;
              else                 r_state <= S_WARMUP;
            end
          end
          S_WARMUP: begin
            if (r_count0 == WARM_LAST) begin
              r_count0 <= '0;
              r_state  <= r_mode ? S_RUN_APX : S_RUN_ACC;
            end else begin
              r_count0 <= r_count0 + 9'd1;
            end
          end
          S_RUN_ACC, S_RUN_APX: begin
            if (w_accept) begin
              r_count0 <= r_count0 + 9'd1;
              if (r_count0 == r_num_ops - 9'd1) r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (r_sr == '0) begin
              r_state  <= S_IDLE;
              r_count0 <= '0;
              r_done   <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef CONF_MUL_SEQ_PERF_CNT_EN
  logic [15:0] r_apx_ops;
  // Saturating and deliberately untouched by abort so it reflects all approximate work issued.
  always_ff @(posedge clk) begin
    if (rstP)
      r_apx_ops <= '0;
    else if (w_accept && (r_state == S_RUN_APX) && (r_apx_ops != 16'hFFFF))
      r_apx_ops <= r_apx_ops + 16'd1;
  end
  assign apx_ops = r_apx_ops;
`endif

  assign state     = r_state;
  assign count0    = r_count0;
  assign busy      = w_busy;
  assign racc      = (r_state == S_IDLE);
  assign mul_rstP  = (r_state == S_IDLE) || (r_state == S_WARMUP);
  assign rapx      = w_busy && r_mode;
  assign out_valid = r_sr[LAT-1];
  assign done      = r_done;

endmodule
